reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter.sv | 112 +++++++++++
 tb/tb_reg_bus_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter sharing one register bus among NREQ requesters,
// with a bounded wait for the target acknowledge and an error completion on timeout.
module reg_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 11,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     sys_clk,
    input  logic                     sys_reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [DW-1:0]            req_rdata,
    output logic                     req_err,
    output logic                     reg_cs,
    output logic                     reg_write,
    output logic [AW-1:0]            reg_addr,
    output logic [DW-1:0]            reg_wdata,
    input  logic [DW-1:0]            reg_rdata,
    input  logic                     reg_ack,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t          state_q;
    logic [GW-1:0]   grant_q, last_q, pick_d, idx;
    logic            pick_vld_d;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] req_ack_q, ack_vec;
    logic [DW-1:0]   req_rdata_q, reg_wdata_q;
    logic [AW-1:0]   reg_addr_q;
    logic            req_err_q, reg_cs_q, reg_write_q, busy_q;
    // Walk downward so the closest requester after last_q wins; i = NREQ revisits last_q itself.
    always_comb begin
        pick_d = last_q;
        pick_vld_d = 1'b0;
        idx = last_q;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last_q + GW'(i);
            if (req_valid[idx]) begin
                pick_d = idx;
                pick_vld_d = 1'b1;
            end
        end
        ack_vec = NREQ'(1) << grant_q;
    end
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state_q     <= IDLE;
            last_q      <= GW'(NREQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            req_ack_q   <= '0;
            req_err_q   <= 1'b0;
            req_rdata_q <= '0;
            reg_cs_q    <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            req_ack_q <= '0;
            req_err_q <= 1'b0;
            reg_cs_q  <= 1'b0;
            case (state_q)
                IDLE: if (pick_vld_d) begin
                    grant_q     <= pick_d;
                    reg_write_q <= req_write[pick_d];
                    reg_addr_q  <= req_addr[int'(pick_d)*AW +: AW];
                    reg_wdata_q <= req_wdata[int'(pick_d)*DW +: DW];
                    reg_cs_q    <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE, WAIT: begin
                    cnt_q <= (state_q == ISSUE) ? '0 : (reg_ack ? cnt_q : cnt_q + 1'b1);
                    if (reg_ack) begin
                        req_rdata_q <= reg_rdata;
                        req_ack_q   <= ack_vec;
                        state_q     <= DONE;
                    end else if (state_q == ISSUE) begin
                        state_q <= WAIT;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        req_rdata_q <= '0;
                        req_err_q   <= 1'b1;
                        req_ack_q   <= ack_vec;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    last_q  <= grant_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign req_ack   = req_ack_q;
    assign req_rdata = req_rdata_q;
    assign req_err   = req_err_q;
    assign reg_cs    = reg_cs_q;
    assign reg_write = reg_write_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed scenarios for reg_bus_arbiter with NREQ=4 and TIMEOUT=8.
module tb_reg_bus_arbiter;
    localparam int NREQ = 4;
    localparam int AW = 11;
    localparam int DW = 32;
    logic                sys_clk = 1'b0;
    logic                sys_reset_n;
    logic [NREQ-1:0]     req_valid, req_write, req_ack;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [DW-1:0]       req_rdata, reg_wdata, reg_rdata;
    logic                req_err, reg_cs, reg_write, reg_ack, busy;
    logic [AW-1:0]       reg_addr;
    logic [1:0]          grant_id;
    int n_chk = 0;
    int n_fail = 0;

    reg_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
        .reg_cs(reg_cs), .reg_write(reg_write), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .grant_id(grant_id), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic test_reset;
        @(negedge sys_clk);
        sys_reset_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        reg_ack = 1'b0; reg_rdata = '0;
        repeat (2) @(negedge sys_clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_chk++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL rst_ack got %b exp 0000", req_ack); end
        n_chk++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", req_err); end
        n_chk++; if (req_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", req_rdata); end
        n_chk++; if ({reg_cs, reg_write} !== 2'b00) begin n_fail++; $display("FAIL rst_cs_wr got %b exp 00", {reg_cs, reg_write}); end
        n_chk++; if ({reg_addr, reg_wdata} !== '0) begin n_fail++; $display("FAIL rst_addr_wdata got %h/%h exp 0/0", reg_addr, reg_wdata); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant got %0d exp 0", grant_id); end
        sys_reset_n = 1'b1;
    endtask

    task automatic test_single_read;
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 11'h0AA;
        @(negedge sys_clk);
        n_chk++; if ({reg_cs, busy, reg_write} !== 3'b110) begin n_fail++; $display("FAIL rd_issue cs/busy/wr got %b exp 110", {reg_cs, busy, reg_write}); end
        n_chk++; if (grant_id !== 2'd2 || reg_addr !== 11'h0AA) begin n_fail++; $display("FAIL rd_grant got %0d/%h exp 2/0aa", grant_id, reg_addr); end
        reg_ack = 1'b1; reg_rdata = 32'hCAFE0001;
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL rd_ack got %b exp 0100", req_ack); end
        n_chk++; if (req_rdata !== 32'hCAFE0001 || req_err !== 1'b0) begin n_fail++; $display("FAIL rd_data got %h err %b exp cafe0001 err 0", req_rdata, req_err); end
        n_chk++; if (reg_cs !== 1'b0) begin n_fail++; $display("FAIL rd_cs_done got %b exp 0", reg_cs); end
        req_valid = '0; reg_ack = 1'b0;
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle ack %b busy %b exp 0000 0", req_ack, busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ack;
        req_valid = 4'b1111; reg_ack = 1'b1; reg_rdata = 32'h11110000;
        for (int k = 1; k <= 15; k++) begin
            @(negedge sys_clk);
            exp_ack = (k % 3 == 2) ? 4'(1 << (((k - 2) / 3) % 4)) : 4'b0;
            n_chk++; if (req_ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack k=%0d got %b exp %b", k, req_ack, exp_ack); end
            if (k % 3 == 1) begin
                n_chk++; if (grant_id !== 2'(((k - 1) / 3) % 4) || reg_cs !== 1'b1) begin n_fail++; $display("FAIL rr_grant k=%0d got %0d cs %b exp %0d cs 1", k, grant_id, reg_cs, ((k - 1) / 3) % 4); end
            end
        end
        req_valid = '0; reg_ack = 1'b0;
    endtask

    task automatic test_timeout;
        req_valid = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sys_clk);
            if (k == 1) begin
                n_chk++; if (grant_id !== 2'd3 || reg_cs !== 1'b1) begin n_fail++; $display("FAIL to_grant got %0d cs %b exp 3 cs 1", grant_id, reg_cs); end
            end
            if (k == 5) begin
                n_chk++; if (busy !== 1'b1 || reg_cs !== 1'b0) begin n_fail++; $display("FAIL to_wait busy %b cs %b exp 1 0", busy, reg_cs); end
            end
            if (k < 10) begin
                n_chk++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL to_early_ack k=%0d got %b exp 0000", k, req_ack); end
            end
        end
        n_chk++; if (req_ack !== 4'b1000 || req_err !== 1'b1) begin n_fail++; $display("FAIL to_ack got %b err %b exp 1000 err 1", req_ack, req_err); end
        n_chk++; if (req_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h exp 0", req_rdata); end
        req_valid = '0;
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0 || req_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_after ack %b err %b busy %b exp 0000 0 0", req_ack, req_err, busy); end
    endtask

    task automatic test_ack_last_wait;
        req_valid = 4'b0001; reg_rdata = 32'h5A5A1234;
        for (int k = 1; k <= 9; k++) @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL alw_pre ack %b busy %b exp 0000 1", req_ack, busy); end
        reg_ack = 1'b1;
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0001 || req_err !== 1'b0) begin n_fail++; $display("FAIL alw_ack got %b err %b exp 0001 err 0", req_ack, req_err); end
        n_chk++; if (req_rdata !== 32'h5A5A1234) begin n_fail++; $display("FAIL alw_rdata got %h exp 5a5a1234", req_rdata); end
        req_valid = '0; reg_ack = 1'b0;
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL alw_after got %b exp 0000", req_ack); end
    endtask

    task automatic test_write_drop;
        req_valid = 4'b0010; req_write = 4'b0010;
        req_addr[1*AW +: AW] = 11'h120; req_wdata[1*DW +: DW] = 32'h5;
        @(negedge sys_clk);
        n_chk++; if (reg_cs !== 1'b1 || reg_write !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL wr_issue cs %b wr %b grant %0d exp 1 1 1", reg_cs, reg_write, grant_id); end
        n_chk++; if (reg_addr !== 11'h120 || reg_wdata !== 32'h5) begin n_fail++; $display("FAIL wr_attr got %h/%h exp 120/5", reg_addr, reg_wdata); end
        @(negedge sys_clk);
        req_valid = '0; req_write = '0;
        req_addr[1*AW +: AW] = 11'h7FF; req_wdata[1*DW +: DW] = 32'hDEADBEEF;
        @(negedge sys_clk);
        n_chk++; if (reg_addr !== 11'h120 || reg_wdata !== 32'h5 || reg_write !== 1'b1) begin n_fail++; $display("FAIL wr_wait_attr got %h/%h/%b exp 120/5/1", reg_addr, reg_wdata, reg_write); end
        @(negedge sys_clk);
        reg_ack = 1'b1;
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0010 || req_err !== 1'b0) begin n_fail++; $display("FAIL wr_ack got %b err %b exp 0010 err 0", req_ack, req_err); end
        n_chk++; if (reg_addr !== 11'h120 || reg_wdata !== 32'h5 || reg_write !== 1'b1) begin n_fail++; $display("FAIL wr_done_attr got %h/%h/%b exp 120/5/1", reg_addr, reg_wdata, reg_write); end
        reg_ack = 1'b0;
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_after ack %b busy %b exp 0000 0", req_ack, busy); end
    endtask

    task automatic test_reset_in_wait;
        req_valid = 4'b0100;
        @(negedge sys_clk);
        n_chk++; if (grant_id !== 2'd2 || reg_cs !== 1'b1) begin n_fail++; $display("FAIL rw_grant got %0d cs %b exp 2 cs 1", grant_id, reg_cs); end
        repeat (2) @(negedge sys_clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rw_busy got %b exp 1", busy); end
        sys_reset_n = 1'b0; req_valid = '0;
        @(negedge sys_clk);
        n_chk++; if (busy !== 1'b0 || req_ack !== 4'b0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rw_reset busy %b ack %b grant %0d exp 0 0000 0", busy, req_ack, grant_id); end
        sys_reset_n = 1'b1; reg_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            n_chk++; if (req_ack !== 4'b0 || busy !== 1'b0 || reg_cs !== 1'b0) begin n_fail++; $display("FAIL rw_late_ack k=%0d ack %b busy %b cs %b exp 0000 0 0", k, req_ack, busy, reg_cs); end
        end
        reg_ack = 1'b0;
    endtask

    task automatic test_priority;
        req_valid = 4'b1010; reg_ack = 1'b1;
        @(negedge sys_clk);
        n_chk++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL pri_first got %0d exp 1", grant_id); end
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL pri_ack1 got %b exp 0010", req_ack); end
        repeat (2) @(negedge sys_clk);
        n_chk++; if (grant_id !== 2'd3 || reg_cs !== 1'b1) begin n_fail++; $display("FAIL pri_second got %0d cs %b exp 3 cs 1", grant_id, reg_cs); end
        @(negedge sys_clk);
        n_chk++; if (req_ack !== 4'b1000) begin n_fail++; $display("FAIL pri_ack2 got %b exp 1000", req_ack); end
        req_valid = '0; reg_ack = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pri_idle busy %b exp 0", busy); end
    endtask

    initial begin
        sys_reset_n = 1'b0;
        test_reset;
        test_single_read;
        test_reset;
        test_round_robin;
        test_timeout;
        test_ack_last_wait;
        test_write_drop;
        test_reset_in_wait;
        test_priority;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
